// File: rtl/aer_taxel_readout_ctrl.sv
// AER readout controller for a NOR-latch taxel array: grants rows round-robin,
// scans columns in ascending order, emits timestamped events and pulses column acks.
module aer_taxel_readout_ctrl #(
  parameter int NROWS         = 8,
  parameter int NCOLS         = 8,
  parameter int ROW_W         = 3,
  parameter int COL_W         = 3,
  parameter int TS_W          = 16,
  parameter int SETTLE_CYC    = 2,
  parameter int ACK_PULSE_CYC = 2,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NROWS-1:0] row_req,
  input  logic [NCOLS-1:0] col_req,
  output logic [NROWS-1:0] acky,
  output logic [NCOLS-1:0] ackx_pulse,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [ROW_W-1:0] ev_row,
  output logic [COL_W-1:0] ev_col,
  output logic [TS_W-1:0]  ev_ts,
  output logic             err_timeout
);

  localparam int SYNC_LAT = 2;
  localparam int CNT_W    = 16;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC + SYNC_LAT - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(ACK_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, ROW_SETTLE, COL_SCAN, EMIT, COL_ACK, COL_WAIT, ROW_REL
  } state_t;

  state_t             state;
  logic [NROWS-1:0]   row_s1, row_s2;
  logic [NCOLS-1:0]   col_s1, col_s2;
  logic [TS_W-1:0]    ts;
  logic [ROW_W-1:0]   row_ptr, grant_row;
  logic [COL_W-1:0]   cur_col;
  logic [NCOLS-1:0]   col_mask;
  logic [CNT_W-1:0]   cnt;

  logic [2*NROWS-1:0] row_dbl;
  logic [NROWS-1:0]   row_rot;
  logic               row_hit;
  int unsigned        row_off, row_sum;
  logic [ROW_W-1:0]   row_pick;
  logic [NCOLS-1:0]   col_avail;
  logic               col_hit;
  logic [COL_W-1:0]   col_pick;

  // Rotate requests so bit 0 is the row pointer; the lowest set bit is the next grant.
  always_comb begin
    row_dbl = {row_s2, row_s2} >> row_ptr;
    row_rot = row_dbl[NROWS-1:0];
    row_hit = 1'b0;
    row_off = 0;
    for (int unsigned i = 0; i < NROWS; i++) begin
      if (!row_hit && row_rot[i]) begin
        row_hit = 1'b1;
        row_off = i;
      end
    end
    row_sum = 32'(row_ptr) + row_off;
    if (row_sum >= NROWS) row_sum = row_sum - NROWS;
    row_pick = ROW_W'(row_sum);
  end

  always_comb begin
    col_avail = col_s2 & ~col_mask;
    col_hit   = 1'b0;
    col_pick  = '0;
    for (int unsigned i = 0; i < NCOLS; i++) begin
      if (!col_hit && col_avail[i]) begin
        col_hit  = 1'b1;
        col_pick = COL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_s1      <= '0;
      row_s2      <= '0;
      col_s1      <= '0;
      col_s2      <= '0;
      ts          <= '0;
      row_ptr     <= '0;
      grant_row   <= '0;
      cur_col     <= '0;
      col_mask    <= '0;
      cnt         <= '0;
      acky        <= '0;
      ackx_pulse  <= '0;
      ev_valid    <= 1'b0;
      ev_row      <= '0;
      ev_col      <= '0;
      ev_ts       <= '0;
      err_timeout <= 1'b0;
    end else begin
      row_s1 <= row_req;
      row_s2 <= row_s1;
      col_s1 <= col_req;
      col_s2 <= col_s1;
      ts     <= ts + TS_W'(1);
      case (state)
        IDLE: begin
          if (row_hit) begin
            grant_row <= row_pick;
            acky      <= NROWS'(1) << row_pick;
            cnt       <= '0;
            state     <= ROW_SETTLE;
          end
        end
        ROW_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= COL_SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COL_SCAN: begin
          if (col_hit) begin
            cur_col  <= col_pick;
            ev_row   <= grant_row;
            ev_col   <= col_pick;
            ev_ts    <= ts;
            ev_valid <= 1'b1;
            state    <= EMIT;
          end else begin
            state <= ROW_REL;
          end
        end
        EMIT: begin
          if (ev_ready) begin
            ev_valid   <= 1'b0;
            ackx_pulse <= NCOLS'(1) << cur_col;
            cnt        <= '0;
            state      <= COL_ACK;
          end
        end
        COL_ACK: begin
          if (cnt == PULSE_LAST) begin
            ackx_pulse <= '0;
            cnt        <= '0;
            state      <= COL_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        COL_WAIT: begin
          if (!col_s2[cur_col]) begin
            cnt   <= '0;
            state <= COL_SCAN;
          end else if (cnt == TIMEOUT_LAST) begin
            // A stuck column is masked so the rescan can move past it.
            err_timeout       <= 1'b1;
            col_mask[cur_col] <= 1'b1;
            cnt               <= '0;
            state             <= COL_SCAN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ROW_REL: begin
          acky     <= '0;
          col_mask <= '0;
          row_ptr  <= (grant_row == ROW_W'(NROWS - 1)) ? '0 : grant_row + ROW_W'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_taxel_readout_ctrl.sv
// Bench for aer_taxel_readout_ctrl: a behavioural taxel latch array drives the
// request lines; expected grants and events come from round-robin planning over it.
module tb_aer_taxel_readout_ctrl;

  localparam int NROWS         = 8;
  localparam int NCOLS         = 8;
  localparam int ROW_W         = 3;
  localparam int COL_W         = 3;
  localparam int TS_W          = 16;
  localparam int SETTLE_CYC    = 2;
  localparam int ACK_PULSE_CYC = 2;
  localparam int TIMEOUT_CYC   = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NROWS-1:0] row_req;
  logic [NCOLS-1:0] col_req;
  logic [NROWS-1:0] acky;
  logic [NCOLS-1:0] ackx_pulse;
  logic             ev_valid;
  logic             ev_ready;
  logic [ROW_W-1:0] ev_row;
  logic [COL_W-1:0] ev_col;
  logic [TS_W-1:0]  ev_ts;
  logic             err_timeout;

  aer_taxel_readout_ctrl #(
    .NROWS(NROWS), .NCOLS(NCOLS), .ROW_W(ROW_W), .COL_W(COL_W), .TS_W(TS_W),
    .SETTLE_CYC(SETTLE_CYC), .ACK_PULSE_CYC(ACK_PULSE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_req(row_req), .col_req(col_req),
    .acky(acky), .ackx_pulse(ackx_pulse), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_row(ev_row), .ev_col(ev_col), .ev_ts(ev_ts), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release: the timestamp the design should be carrying.
  int edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [NCOLS-1:0] latch [NROWS];
  logic [NROWS-1:0] spur;
  logic [NCOLS-1:0] stuck;
  int               ptr;
  int               ev_q[$];
  int               gnt_q[$];
  int               last_row, last_col;
  logic             prev_valid;
  logic [NROWS-1:0] prev_acky;
  logic [ROW_W-1:0] prev_row;
  logic [COL_W-1:0] prev_col;
  logic [TS_W-1:0]  prev_ts;
  int               pw, pulses, events, stall_left, rdy_pct;
  bit               stall_req, hold_ready;

  task automatic drive();
    logic [NCOLS-1:0] cr;
    cr = '0;
    for (int r = 0; r < NROWS; r++) begin
      row_req[r] = (latch[r] != '0) || spur[r];
      if (acky[r]) cr |= latch[r];
    end
    if (acky != '0) cr |= stuck;
    col_req = cr;
  endtask

  // Expected service order for everything currently latched: rows circularly from
  // the pointer, ascending columns within a row; pointer ends after the last row.
  task automatic plan();
    int last;
    last = -1;
    for (int k = 0; k < NROWS; k++) begin
      int r;
      r = (ptr + k) % NROWS;
      if (latch[r] != '0 || spur[r]) begin
        gnt_q.push_back(r);
        last = r;
        for (int c = 0; c < NCOLS; c++)
          if (latch[r][c]) ev_q.push_back(r * 256 + c);
      end
    end
    if (last >= 0) ptr = (last + 1) % NROWS;
  endtask

  task automatic step();
    logic rdy;
    int   e;
    @(negedge clk);
    chk("acky_onehot", 32'($onehot0(acky)), 32'd1);
    chk("ackx_onehot", 32'($onehot0(ackx_pulse)), 32'd1);
    if (ackx_pulse != '0) chk("ackx_without_acky", 32'(acky != '0), 32'd1);
    if (ev_valid) chk("ackx_during_valid", 32'(ackx_pulse), 32'd0);

    if (acky != '0 && prev_acky == '0) begin
      if (gnt_q.size() == 0) chk("grant_extra", 32'(acky), 32'd0);
      else chk("grant_row", 32'(acky), 32'd1 << gnt_q.pop_front());
    end else if (acky != '0) begin
      chk("acky_stable", 32'(acky), 32'(prev_acky));
    end

    if (ev_valid && !prev_valid) begin
      chk("ev_ts", 32'(ev_ts), 32'((edges - 1) % (1 << TS_W)));
    end else if (ev_valid && prev_valid) begin
      chk("hold_row", 32'(ev_row), 32'(prev_row));
      chk("hold_col", 32'(ev_col), 32'(prev_col));
      chk("hold_ts", 32'(ev_ts), 32'(prev_ts));
    end

    if (ackx_pulse != '0 && pw == 0) begin
      pulses++;
      chk("pulse_col", 32'(ackx_pulse), 32'd1 << last_col);
      chk("pulse_acky", 32'(acky), 32'd1 << last_row);
    end
    if (ackx_pulse != '0) pw++;
    else if (pw != 0) begin
      chk("pulse_width", 32'(pw), 32'(ACK_PULSE_CYC));
      pw = 0;
    end

    if (ev_valid && !prev_valid && stall_req) begin
      stall_left = 20;
      stall_req  = 0;
    end
    if (hold_ready) rdy = 1'b0;
    else if (stall_left > 0 && ev_valid) begin
      rdy = 1'b0;
      stall_left--;
    end else rdy = ($urandom_range(99) < 32'(rdy_pct));
    ev_ready = rdy;

    if (ev_valid && rdy) begin
      events++;
      if (ev_q.size() == 0) chk("ev_extra", 32'({ev_row, ev_col}), 32'hFFFF_FFFF);
      else begin
        e = ev_q.pop_front();
        chk("ev_row", 32'(ev_row), 32'(e / 256));
        chk("ev_col", 32'(ev_col), 32'(e % 256));
        last_row = e / 256;
        last_col = e % 256;
      end
    end

    prev_valid = ev_valid;
    prev_acky  = acky;
    prev_row   = ev_row;
    prev_col   = ev_col;
    prev_ts    = ev_ts;

    // Latch reset term of the array: acky[r] & ackx_pulse[c].
    for (int r = 0; r < NROWS; r++) begin
      if (acky[r]) begin
        latch[r] = latch[r] & ~ackx_pulse;
        spur[r]  = 1'b0;
      end
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 8 && n < budget) begin
      step();
      n++;
      if (acky == '0 && !ev_valid && row_req == '0) quiet++;
      else quiet = 0;
    end
    chk("drain_done", 32'(quiet >= 8), 32'd1);
    chk("ev_q_empty", 32'(ev_q.size()), 32'd0);
    chk("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
    chk("pulses_vs_events", 32'(pulses), 32'(events));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < NROWS; r++) latch[r] = '0;
    spur = '0; stuck = '0; ptr = 0;
    ev_q.delete(); gnt_q.delete();
    prev_valid = 1'b0; prev_acky = '0;
    pw = 0; pulses = 0; events = 0;
    stall_left = 0; stall_req = 0; hold_ready = 0;
    ev_ready = 1'b0;
    drive();
    #1;
    chk("rst_acky", 32'(acky), 32'd0);
    chk("rst_ackx", 32'(ackx_pulse), 32'd0);
    chk("rst_ev_valid", 32'(ev_valid), 32'd0);
    chk("rst_ev_row", 32'(ev_row), 32'd0);
    chk("rst_ev_col", 32'(ev_col), 32'd0);
    chk("rst_ev_ts", 32'(ev_ts), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    ev_ready = 1'b0;
    row_req = '0;
    col_req = '0;
    last_row = 0;
    last_col = 0;
    rdy_pct = 100;
    #2;
    do_reset();

    latch[2][5] = 1'b1;
    plan(); drive(); drain(400);

    latch[1] = 8'b1000_1001;
    plan(); drive(); drain(600);

    do_reset();
    latch[0][4] = 1'b1;
    latch[6][4] = 1'b1;
    plan(); drive(); drain(600);
    latch[7][1] = 1'b1;
    latch[1][1] = 1'b1;
    plan(); drive(); drain(600);

    stall_req = 1;
    latch[5][3] = 1'b1;
    plan(); drive(); drain(600);

    rdy_pct = 70;
    for (int it = 0; it < 20; it++) begin
      for (int r = 0; r < NROWS; r++)
        if ($urandom_range(99) < 40) latch[r] = NCOLS'($urandom);
      plan(); drive(); drain(4000);
    end

    rdy_pct = 100;
    spur[5] = 1'b1;
    plan(); drive(); drain(400);
    chk("err_before_timeout", 32'(err_timeout), 32'd0);

    latch[3][2] = 1'b1;
    latch[3][5] = 1'b1;
    stuck[2] = 1'b1;
    plan(); drive(); drain(1500);
    chk("err_after_timeout", 32'(err_timeout), 32'd1);
    stuck = '0;
    drive();

    hold_ready = 1;
    latch[4][1] = 1'b1;
    plan(); drive();
    n = 0;
    while (!ev_valid && n < 100) begin
      step();
      n++;
    end
    chk("emit_reached", 32'(ev_valid), 32'd1);
    chk("err_sticky", 32'(err_timeout), 32'd1);
    do_reset();

    latch[6][0] = 1'b1;
    plan(); drive(); drain(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
